hdlc_tx_serializer: RTL

Parametrised parallel-to-serial transmitter stage for the HDLC controller TX path. Accepts DATA_W-bit words over a valid/ready handshake and shifts them out one bit per bit-rate strobe, LSB- or MSB-first. HDLC zero-bit insertion is optional: a 0 follows every ONES_MAX consecutive 1s, counted across word boundaries. Sits between the TX framer (flags, payload, FCS) and the line driver.

---
 rtl/hdlc_pkg.sv | 13 +
 rtl/hdlc_bit_sel.sv | 20 ++
 rtl/hdlc_tx_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC TX definitions: serializer state encoding and the standard
// zero-insertion run length.
package hdlc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } hdlc_state_t;

  localparam int HDLC_ONES_MAX = 5;

endpackage

// File: rtl/hdlc_bit_sel.sv
// Combinational DATA_W:1 selector picking the bit at transmit position idx,
// counting from bit 0 (LSB first) or from bit DATA_W-1 (MSB first).
module hdlc_bit_sel #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [DATA_W-1:0]         word,
  input  logic [$clog2(DATA_W)-1:0] idx,
  output logic                      sel_bit
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic [IDX_W-1:0] pos;

  assign pos     = LSB_FIRST ? idx : (IDX_LAST - idx);
  assign sel_bit = word[pos];

endmodule

// File: rtl/hdlc_tx_serializer.sv
// HDLC TX parallel-to-serial stage: one line bit per bit_en strobe, with
// optional zero-bit insertion whose ones run carries across gapless words.
module hdlc_tx_serializer
  import hdlc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit STUFF_EN  = 1'b1,
  parameter int ONES_MAX  = HDLC_ONES_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              stuff_on,
  output logic              data_ready,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              stuffed,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(ONES_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ONES_MAX);

  hdlc_state_t       state, state_nxt;
  logic [DATA_W-1:0] word;
  logic              stuff_mode, stuff_mode_in;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  ones, ones_nxt, ones_upd;
  logic              data_bit, last_bit, stuff_hit, final_emit, accept;

  function automatic logic [CNT_W-1:0] ones_sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
  endfunction

  hdlc_bit_sel #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_bit_sel (
    .word   (word),
    .idx    (idx),
    .sel_bit(data_bit)
  );

  assign stuff_mode_in = stuff_on & STUFF_EN;

  always_comb begin
    ones_upd   = (stuff_mode && data_bit) ? ones_sat_inc(ones) : '0;
    stuff_hit  = stuff_mode && (ones_upd == CNT_MAX);
    last_bit   = (idx == IDX_LAST);
    final_emit = bit_en && last_bit &&
                 (((state == SHIFT) && !stuff_hit) || (state == STUFF));
    data_ready = (state == IDLE) || final_emit;
  end

  assign accept = data_valid && data_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ones_nxt  = ones;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          idx_nxt   = '0;
          ones_nxt  = '0;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          ones_nxt = ones_upd;
          if (stuff_hit)      state_nxt = STUFF;
          else if (!last_bit) idx_nxt   = idx + 1'b1;
        end
      end
      STUFF: begin
        if (bit_en) begin
          ones_nxt = '0;
          if (!last_bit) begin
            idx_nxt   = idx + 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Word boundary: either chain straight into the next word or drop to idle
    if (final_emit) begin
      if (accept) begin
        state_nxt = SHIFT;
        idx_nxt   = '0;
        if (!stuff_mode_in) ones_nxt = '0;
      end else begin
        state_nxt = IDLE;
        ones_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      ones         <= '0;
      stuff_mode   <= 1'b0;
      serial_out   <= 1'b1;
      serial_valid <= 1'b0;
      stuffed      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      ones         <= ones_nxt;
      serial_valid <= bit_en && (state != IDLE);
      stuffed      <= bit_en && (state == STUFF);
      busy         <= (state_nxt != IDLE);
      if (accept)
        stuff_mode <= stuff_mode_in;
      if (bit_en && (state == SHIFT))
        serial_out <= data_bit;
      else if (bit_en && (state == STUFF))
        serial_out <= 1'b0;
    end
  end

  // Payload register: only meaningful after an accept, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept)
      word <= data_in;
  end

endmodule
